// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared types for the sequential magnitude comparator:
//               the controller state encoding and the one-hot result codes
//               held in the result register.
// Contents    : state_t              IDLE / SCAN / DONE (2-bit)
//               RES_GT/RES_LT/RES_EQ one-hot {gt, lt, eq} result codes
//               RES_NONE             no result latched
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result register layout is {gt, lt, eq}.
   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_LT   = 3'b010;
   localparam logic [2:0] RES_EQ   = 3'b001;
   localparam logic [2:0] RES_NONE = 3'b000;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/chunk_cmp.sv
`default_nettype none
// ============================================================================
// Module      : chunk_cmp
// Description : Purely combinational unsigned magnitude compare of one
//               CHUNK-bit slice. Exactly one of gt/lt/eq is high.
// Parameters  : CHUNK  slice width in bits
// Ports       : a   in  CHUNK  slice of operand A
//               b   in  CHUNK  slice of operand B
//               gt  out 1      a > b
//               lt  out 1      a < b
//               eq  out 1      a == b
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_cmp #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule : chunk_cmp
`default_nettype wire

// File: rtl/seq_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : seq_mag_comparator
// Description : Multi-cycle magnitude comparator for wide operands. Scans the
//               captured operands MSB-first, CHUNK bits per cycle, and stops
//               on the first differing chunk. Result is one-hot gt/lt/eq,
//               presented on a valid/ready output; operands arrive on a
//               valid/ready input accepted only in IDLE.
// Parameters  : WIDTH  operand width (multiple of CHUNK)
//               CHUNK  bits compared per cycle
// Macro       : CMP_SIGNED_EN - adds the sgn port; sgn=1 selects a
//               two's-complement compare, otherwise unsigned.
// Ports       : clock      in  1      rising-edge clock
//               reset_n    in  1      asynchronous active-low reset
//               in_valid   in  1      operands valid
//               in_ready   out 1      operands accepted (IDLE only)
//               a, b       in  WIDTH  operands
//               sgn        in  1      signed compare (CMP_SIGNED_EN only)
//               out_valid  out 1      result valid (DONE)
//               out_ready  in  1      consumer accepts result
//               gt/lt/eq   out 1      one-hot result, all 0 when not valid
//               busy       out 1      high in SCAN and DONE
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
   input  logic             sgn,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             lt,
   output logic             eq,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [IDX_W-1:0]   r_idx;
   logic [2:0]         r_result;

   logic               w_flip;
   logic [CHUNK-1:0]   w_chunk_a;
   logic [CHUNK-1:0]   w_chunk_b;
   logic               w_gt;
   logic               w_lt;
   logic               w_eq;
   logic               w_idx_zero;

   // Inverting the sign bit of both operands maps two's-complement order onto
   // unsigned order; it is applied once at capture so the scan stays unsigned.
`ifdef CMP_SIGNED_EN
   assign w_flip = sgn;
`else
   assign w_flip = 1'b0;
`endif

   // Single slice comparator, fed by an index mux over the captured operands.
   assign w_chunk_a  = r_a[r_idx*CHUNK +: CHUNK];
   assign w_chunk_b  = r_b[r_idx*CHUNK +: CHUNK];
   assign w_idx_zero = (r_idx == '0);

   chunk_cmp #(
      .CHUNK (CHUNK)
   ) u_chunk_cmp (
      .a  (w_chunk_a),
      .b  (w_chunk_b),
      .gt (w_gt),
      .lt (w_lt),
      .eq (w_eq)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and outputs
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      gt          = 1'b0;
      lt          = 1'b0;
      eq          = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            busy = 1'b1;
            if (w_gt || w_lt || (w_eq && w_idx_zero)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            gt        = (r_result == RES_GT);
            lt        = (r_result == RES_LT);
            eq        = (r_result == RES_EQ);
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, chunk index and result latch
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_idx    <= '0;
         r_result <= RES_NONE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= a ^ (w_flip ? MSB_MASK : '0);
                  r_b      <= b ^ (w_flip ? MSB_MASK : '0);
                  r_idx    <= IDX_W'(NCHUNK - 1);
                  r_result <= RES_NONE;
               end
            end
            SCAN: begin
               if (w_gt) begin
                  r_result <= RES_GT;
               end else if (w_lt) begin
                  r_result <= RES_LT;
               end else if (w_idx_zero) begin
                  r_result <= RES_EQ;
               end else begin
                  r_idx <= r_idx - IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : seq_mag_comparator
`default_nettype wire

// File: tb/tb_seq_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mag_comparator
// Description : Scoreboard bench for seq_mag_comparator (WIDTH=16, CHUNK=4).
//               Directed cases plus a random stream with random input gaps
//               and output stalls, against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mag_comparator;

   localparam int W   = 16;
   localparam int CH  = 4;
   localparam int NCH = W / CH;

   typedef struct {
      logic [2:0] res;      // {gt, lt, eq}
      int         lat;
      int         acc_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          sgn = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          gt, lt, eq, busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_acc    = 0;
   int   n_res    = 0;
   int   cyc      = 0;
   int   rdy_pct  = 100;
   bit   rdy_force_low = 1'b0;
   exp_t sb_q[$];

   seq_mag_comparator #(
      .WIDTH (W),
      .CHUNK (CH)
   ) dut (
      .clock     (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
`ifdef CMP_SIGNED_EN
      .sgn       (sgn),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gt        (gt),
      .lt        (lt),
      .eq        (eq),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference: plain arithmetic compare; latency from the highest differing bit.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input bit s);
      exp_t e;
      logic [W-1:0] d;
      int p;
      d = av ^ bv;
      p = -1;
      for (int i = 0; i < W; i++) if (d[i]) p = i;
      if (s) e.res = ($signed(av) > $signed(bv)) ? 3'b100 : ($signed(av) < $signed(bv)) ? 3'b010 : 3'b001;
      else   e.res = (av > bv) ? 3'b100 : (av < bv) ? 3'b010 : 3'b001;
      e.lat = (p < 0) ? NCH : NCH - (p / CH);
      e.acc_cyc = 0;
      return e;
   endfunction

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_force_low) out_ready = 1'b0;
         else out_ready = ($urandom_range(99) < rdy_pct);
      end
   end

   // Input monitor: push the expected response for every accepted pair.
   initial begin
      exp_t e;
      bit s;
      forever begin
         @(negedge clk);
         if (reset_n && in_valid && in_ready) begin
`ifdef CMP_SIGNED_EN
            s = sgn;
`else
            s = 1'b0;
`endif
            e = model(a, b, s);
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
            n_acc++;
         end
      end
   end

   // Output monitor
   initial begin
      bit seen = 1'b0;
      logic [2:0] held = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            seen = 1'b0;
         end else if (out_valid) begin
            chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
            if (!seen) begin
               if (sb_q.size() == 0) begin
                  fail_now("unexpected_result");
               end else begin
                  e = sb_q.pop_front();
                  n_res++;
                  chk("result", {29'd0, gt, lt, eq}, {29'd0, e.res});
                  chk("latency", cyc - e.acc_cyc, e.lat);
                  chk("latency_range", {31'd0, ((cyc - e.acc_cyc) >= 1) && ((cyc - e.acc_cyc) <= NCH)}, 32'd1);
               end
               chk("onehot", {31'd0, $onehot({gt, lt, eq})}, 32'd1);
               held = {gt, lt, eq};
               seen = 1'b1;
            end else begin
               chk("result_stable", {29'd0, gt, lt, eq}, {29'd0, held});
            end
            if (out_ready) seen = 1'b0;
         end else begin
            chk("outputs_zero_when_invalid", {29'd0, gt, lt, eq}, 32'd0);
         end
      end
   end

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input bit sv);
      int waited = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = av;
      b = bv;
      sgn = sv;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) begin
            fail_now("accept_timeout");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      sgn = 1'($urandom);
   endtask

   task automatic drain();
      int waited = 0;
      while (sb_q.size() != 0 || busy) begin
         @(negedge clk);
         waited++;
         if (waited > 500) begin
            fail_now("drain_timeout");
            break;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_gt_lt_eq"}, {29'd0, gt, lt, eq}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] av, bv, mask;
      bit sv;
      int waited;
      int flushed;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Directed cases
      send(16'hA000, 16'h9FFF, 1'b0);   // gt, latency 1
      send(16'h1234, 16'h1235, 1'b0);   // lt, latency 4
      drain();

      // Equal operands with the consumer stalled for 5 cycles
      rdy_force_low = 1'b1;
      send(16'hBEEF, 16'hBEEF, 1'b0);
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!out_valid) fail_now("hold_wait");
      repeat (5) @(negedge clk);
      rdy_force_low = 1'b0;
      drain();

      // Reset pulse mid-SCAN aborts the compare
      send(16'hBEEF, 16'hBEEF, 1'b0);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_scan");
      flushed = sb_q.size();
      sb_q.delete();
      n_acc = n_acc - flushed;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      send(16'h0F00, 16'h0E00, 1'b0);
      drain();

`ifdef CMP_SIGNED_EN
      send(16'h8000, 16'h0001, 1'b1);   // signed: lt
      send(16'h8000, 16'h0001, 1'b0);   // unsigned: gt
      drain();
`endif

      // Random stream with input gaps and output stalls
      rdy_pct = 50;
      for (int n = 0; n < 300; n++) begin
         repeat ($urandom_range(2)) @(posedge clk);
         av = W'($urandom);
         case ($urandom_range(3))
            0: bv = W'($urandom);
            1: bv = av;
            default: begin
               mask = 16'hFFFF >> (4 * $urandom_range(1, 3));
               bv = av ^ (W'($urandom) & mask);
            end
         endcase
`ifdef CMP_SIGNED_EN
         sv = 1'($urandom);
`else
         sv = 1'b0;
`endif
         send(av, bv, sv);
      end
      rdy_pct = 100;
      drain();

      chk("results_per_accept", n_res, n_acc);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_seq_mag_comparator
`default_nettype wire
